// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default register address / write data widths
//   REG_ZERO                : hard-wired zero register; writes to it are dropped
//   wb_req_t                : one writeback request (destination address + data)
package regfile_wb_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter owning the rotating priority pointer.
//   clk, rst  : clock, asynchronous active-high reset (pointer returns to 0)
//   req[N]    : request vector (already masked by any freeze condition)
//   advance   : a grant was taken this cycle; move pointer past the winner
//   grant[N]  : one-hot grant, or zero when nothing is requested
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PTR_W = $clog2(N);

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  int unsigned      g;
  logic             found;

  // Scan starting at rr_ptr, wrapping modulo N; first requester seen wins.
  always_comb begin
    grant = '0;
    g     = 0;
    found = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i] && (i == (32'(rr_ptr_q) + off) % N)) begin
          grant[i] = 1'b1;
          g        = i;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = (g == N - 1) ? '0 : PTR_W'(g + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback
// sources with round-robin arbitration and one registered output stage.
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : freeze; no grants and no contention counting while high
//   req_valid/ready : per-requester handshake; ready is one-hot or zero
//   req_addr/data   : flattened per-requester address/data (requester i at i*W)
//   rf_we/wr_addr/wr_data : registered register-file write port
//   fwd_valid       : copy of rf_we for forwarding the in-flight write
//   last_grant      : index of the most recently accepted requester
//   contention_cnt  : saturating count of unstalled cycles with >=2 requests
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_wr_addr,
  output logic [DATA_W-1:0]           rf_wr_data,
  output logic                        fwd_valid,
  output logic [$clog2(NUM_REQ)-1:0]  last_grant,
  output logic [CNT_W-1:0]            contention_cnt
);

  localparam int unsigned LG_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic [LG_W-1:0]    grant_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  int unsigned        n_valid;
  logic               contended;

  logic               rf_we_q,      rf_we_d;
  logic [ADDR_W-1:0]  rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_W-1:0]  rf_wr_data_q, rf_wr_data_d;
  logic [LG_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;

  // Stall masks requests before the arbiter so ready never depends on rf_*.
  assign arb_req = stall ? '0 : req_valid;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (xfer),
    .grant   (grant)
  );

  assign xfer      = |grant;
  assign req_ready = grant;

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = LG_W'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    n_valid = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) n_valid++;
    end
    contended = !stall && (n_valid >= 2);
  end

  // Writes to the zero register are accepted but never reach the file.
  always_comb begin
    rf_we_d      = xfer && (sel_addr != ADDR_W'(REG_ZERO));
    rf_wr_addr_d = xfer ? sel_addr  : rf_wr_addr_q;
    rf_wr_data_d = xfer ? sel_data  : rf_wr_data_q;
    last_grant_d = xfer ? grant_idx : last_grant_q;
    cnt_d        = (contended && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q      <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      last_grant_q <= '0;
      cnt_q        <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rf_we          = rf_we_q;
  assign fwd_valid      = rf_we_q;
  assign rf_wr_addr     = rf_wr_addr_q;
  assign rf_wr_data     = rf_wr_data_q;
  assign last_grant     = last_grant_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic        rf_we;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        fwd_valid;
  logic [1:0]  last_grant;
  logic [15:0] contention_cnt;

  // Second instance with a narrow counter for saturation.
  logic        s_stall = 1'b0;
  logic [2:0]  s_valid = '0;
  logic [2:0]  s_ready;
  logic [14:0] s_addr = {5'd3, 5'd2, 5'd1};
  logic [95:0] s_data = '0;
  logic        s_we;
  logic [4:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic        s_fwd;
  logic [1:0]  s_lg;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .rf_we(rf_we), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .fwd_valid(fwd_valid), .last_grant(last_grant),
    .contention_cnt(contention_cnt)
  );

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .stall(s_stall), .req_valid(s_valid), .req_ready(s_ready),
    .req_addr(s_addr), .req_data(s_data), .rf_we(s_we), .rf_wr_addr(s_wr_addr),
    .rf_wr_data(s_wr_data), .fwd_valid(s_fwd), .last_grant(s_lg),
    .contention_cnt(s_cnt)
  );

  typedef struct {
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  lg;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   pending = 0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input wb_req_t r);
    req_addr[i*5 +: 5]   = r.addr;
    req_data[i*32 +: 32] = r.data;
  endtask

  // Hand-written expectation for a grant to requester g with request r.
  task automatic expect_grant(input int g, input wb_req_t r);
    exp_t e;
    e.ready = 3'b001 << g;
    e.we    = (r.addr != REG_ZERO);
    e.addr  = r.addr;
    e.data  = r.data;
    e.lg    = 2'(g);
    q.push_back(e);
  endtask

  // Monitor: at each falling edge, check the output stage for the transfer
  // seen on the previous falling edge, then look for a new transfer.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pending = 0;
    end else begin
      if (pending) begin
        chk("rf_we", {63'd0, rf_we}, {63'd0, cur.we});
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, cur.we});
        chk("rf_wr_addr", {59'd0, rf_wr_addr}, {59'd0, cur.addr});
        chk("rf_wr_data", {32'd0, rf_wr_data}, {32'd0, cur.data});
        chk("last_grant", {62'd0, last_grant}, {62'd0, cur.lg});
      end else begin
        chk("idle_we", {63'd0, rf_we}, 64'd0);
      end
      pending = 0;
      if ((req_valid & req_ready) != 3'b000) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", {61'd0, req_ready}, 64'd0);
        end else begin
          cur = q.pop_front();
          chk("req_ready", {61'd0, req_ready}, {61'd0, cur.ready});
          pending = 1;
        end
      end else if (q.size() != 0) begin
        cur = q.pop_front();
        chk("missing_grant", {61'd0, req_ready}, {61'd0, cur.ready});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam wb_req_t R0 = '{addr: 5'd1, data: 32'hA0A0_0000};
  localparam wb_req_t R1 = '{addr: 5'd2, data: 32'hB1B1_1111};
  localparam wb_req_t R2 = '{addr: 5'd3, data: 32'hC2C2_2222};

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", {63'd0, rf_we}, 64'd0);
    chk("rst_addr", {59'd0, rf_wr_addr}, 64'd0);
    chk("rst_data", {32'd0, rf_wr_data}, 64'd0);
    chk("rst_lg", {62'd0, last_grant}, 64'd0);
    chk("rst_cnt", {48'd0, contention_cnt}, 64'd0);
    chk("rst_ready", {61'd0, req_ready}, 64'd0);
    rst = 1'b0;
    step();

    // Single request
    set_req(0, '{addr: 5'd5, data: 32'hDEAD_BEEF});
    req_valid = 3'b001;
    expect_grant(0, '{addr: 5'd5, data: 32'hDEAD_BEEF});
    step();
    req_valid = 3'b000;
    step();

    // Reset while a write is in flight
    set_req(1, '{addr: 5'd7, data: 32'h0000_7777});
    req_valid = 3'b010;
    expect_grant(1, '{addr: 5'd7, data: 32'h0000_7777});
    step();
    req_valid = 3'b000;
    chk("inflight_we", {63'd0, rf_we}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_we", {63'd0, rf_we}, 64'd0);
    chk("rst_drop_lg", {62'd0, last_grant}, 64'd0);
    step();
    rst = 1'b0;
    step();

    // Round robin from rr_ptr=0
    set_req(0, R0);
    set_req(1, R1);
    set_req(2, R2);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      case (k % 3)
        0: expect_grant(0, R0);
        1: expect_grant(1, R1);
        default: expect_grant(2, R2);
      endcase
      step();
    end
    req_valid = 3'b000;
    chk("rr_cnt", {48'd0, contention_cnt}, 64'd6);
    step();

    // x0 write from requester 1, then rr_ptr must sit at 2
    set_req(1, '{addr: 5'd0, data: 32'h0000_1234});
    req_valid = 3'b010;
    expect_grant(1, '{addr: 5'd0, data: 32'h0000_1234});
    step();
    set_req(1, R1);
    req_valid = 3'b111;
    expect_grant(2, R2);
    step();
    req_valid = 3'b000;
    chk("x0_cnt", {48'd0, contention_cnt}, 64'd7);
    step();

    // Stall: in-flight write completes, no grants, counter frozen
    req_valid = 3'b001;
    expect_grant(0, R0);
    step();
    req_valid = 3'b011;
    stall = 1'b1;
    repeat (3) begin
      #1;
      chk("stall_ready", {61'd0, req_ready}, 64'd0);
      step();
    end
    chk("stall_cnt", {48'd0, contention_cnt}, 64'd7);
    stall = 1'b0;
    expect_grant(1, R1);
    step();
    req_valid = 3'b001;
    expect_grant(0, R0);
    step();
    req_valid = 3'b000;
    chk("unstall_cnt", {48'd0, contention_cnt}, 64'd8);
    step();

    // Back-to-back single requester with rr_ptr=1
    req_valid = 3'b100;
    repeat (3) begin
      expect_grant(2, R2);
      step();
    end
    req_valid = 3'b000;
    step();
    step();

    // Saturation on the 4-bit counter
    s_valid = 3'b110;
    repeat (14) step();
    chk("sat_14", {60'd0, s_cnt}, 64'd14);
    step();
    chk("sat_15", {60'd0, s_cnt}, 64'd15);
    repeat (5) step();
    chk("sat_hold", {60'd0, s_cnt}, 64'd15);
    s_valid = 3'b000;
    step();

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
